// File: rtl/fir_mdc_engine_ctrl.sv
// Job-level control FSM for fir_mdc: launches both streamers and the kernel, counts outputs, reports completion.
// Optional watchdog is compiled in by defining FIR_MDC_ENGINE_TIMEOUT_EN.
module fir_mdc_engine_ctrl #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             trigger_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             kernel_done_i,
    input  logic             kernel_idle_i,
    input  logic             in_stream_ready_i,
    input  logic             out_stream_ready_i,
    output logic             in_req_o,
    output logic             out_req_o,
    output logic             kernel_start_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] out_cnt_o,
    output logic [CNT_W-1:0] len_o,
    output logic             error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STARTUP,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             in_req_q, in_req_d;
    logic             out_req_q, out_req_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             final_done;

`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            wd_expired;

    // Counter holds TIMEOUT_CYCLES-1 in the cycle the limit is reached.
    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    // len_q is never zero while in COMPUTE, so len_q-1 cannot underflow there.
    assign final_done = kernel_done_i && (out_cnt_q == len_q - CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        out_cnt_d = out_cnt_q;
        len_d     = len_q;
        in_req_d  = 1'b0;
        out_req_d = 1'b0;
        start_d   = 1'b0;
`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
        err_d     = err_q;
        wd_d      = wd_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (trigger_i) begin
                    len_d     = len_i;
                    out_cnt_d = '0;
`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                    state_d   = (len_i == '0) ? S_DONE : S_STARTUP;
                end
            end
            S_STARTUP: begin
                if (in_stream_ready_i && out_stream_ready_i) begin
                    in_req_d  = 1'b1;
                    out_req_d = 1'b1;
                    start_d   = 1'b1;
                    state_d   = S_COMPUTE;
`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
                    wd_d      = '0;
`endif
                end
            end
            S_COMPUTE: begin
`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
                wd_d = wd_q + WD_W'(1);
`endif
                if (kernel_done_i) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
                    wd_d      = '0;
`endif
                    if (final_done) begin
                        state_d = S_DRAIN;
                    end
                end
`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
                else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_DRAIN: begin
`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
                wd_d = wd_q + WD_W'(1);
`endif
                if (kernel_idle_i) begin
                    state_d = S_DONE;
                end
`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
                else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Soft clear dominates everything, including a same-cycle trigger.
        if (clear_i) begin
            state_d   = S_IDLE;
            out_cnt_d = '0;
            len_d     = '0;
            in_req_d  = 1'b0;
            out_req_d = 1'b0;
            start_d   = 1'b0;
`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
            err_d     = 1'b0;
            wd_d      = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            in_req_q  <= 1'b0;
            out_req_q <= 1'b0;
            start_q   <= 1'b0;
            out_cnt_q <= '0;
            len_q     <= '0;
`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
            err_q     <= 1'b0;
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            in_req_q  <= in_req_d;
            out_req_q <= out_req_d;
            start_q   <= start_d;
            out_cnt_q <= out_cnt_d;
            len_q     <= len_d;
`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
            err_q     <= err_d;
            wd_q      <= wd_d;
`endif
        end
    end

    assign in_req_o       = in_req_q;
    assign out_req_o      = out_req_q;
    assign kernel_start_o = start_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign out_cnt_o      = out_cnt_q;
    assign len_o          = len_q;

`ifdef FIR_MDC_ENGINE_TIMEOUT_EN
    assign error_o = err_q;
`else
    // Watchdog compiled out: error_o is constant low whatever TIMEOUT_CYCLES is.
    assign error_o = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

endmodule
